indicator_shift_out: RTL and testbench
======================================

# indicator_shift_out

Serializes one meter indicator array (the thermometer/peak-hold bit vector from a channel's position-to-array stage) onto a three-wire shift-register LED chain (serial clock, serial data, latch). It sits directly downstream of the channel pipeline, consumes its `o_valid`/`o_ready`/`o_array` stream, and back-pressures it while a frame is being shifted out. Everything runs on a single clock, and the serial clock is derived internally by a divider.

## Interface
- `width`, 32, number of indicator bits per frame. Must be ≥ 1.
- `clk_div`, 4, number of `clk` cycles per half-period of `o_sclk`. Must be ≥ 1.
- `reset`, input, 1, synchronous, active-high.
- `clk`, input, 1, sole clock. All logic is rising-edge.
- `i_valid`, input, 1, `i_array` is valid.
- `i_ready`, output, 1, block can accept a frame.
- `i_array`, input, `width`, indicator bits. Bit `width-1` is shifted first.
- `o_sclk`, output, 1, serial clock to the LED chain. The chain samples on the rising edge.
- `o_sdata`, output, 1, serial data.
- `o_latch`, output, 1, storage-register latch pulse (active-high).

## Operation
- There is one clock and the reset is synchronous, active-high. With `reset` high at a rising edge, the block forces the following on the next cycle:
  - state = IDLE
  - `o_sclk` = 0, `o_sdata` = 0, `o_latch` = 0
  - shift register and counters cleared
- A handshake presented in a cycle where `reset` is high is ignored.
- `i_ready` = (state == IDLE). It is 1 after reset.
- **IDLE**: `o_sclk` = 0, `o_latch` = 0, `o_sdata` = 0.
  - On `i_valid && i_ready`, capture `i_array` into a `width`-bit shift register, clear the bit and phase counters, and go to SHIFT.
- **SHIFT**: each bit occupies 2·`clk_div` cycles.
  - Low phase: `o_sclk` = 0 for `clk_div` cycles. `o_sdata` = shift-register MSB, stable for the whole bit.
  - High phase: `o_sclk` = 1 for `clk_div` cycles.
  - At the end of the high phase, the shift register shifts left by one (zero fill) and the bit counter increments.
  - After bit `width-1`'s high phase, go to LATCH.
- **LATCH**: `o_sclk` = 0, `o_sdata` = 0, `o_latch` = 1 for `clk_div` cycles, then go to IDLE.
- `i_array` and `i_valid` are don't-care outside the accept cycle. Changes while busy have no effect on the frame in flight.
- Reset mid-frame aborts immediately:
  - no latch pulse is issued
  - partially shifted chain contents are left unlatched
  - the next accepted frame is sent in full
- Counter widths:
  - phase counter: `$clog2(clk_div+1)`
  - bit counter: `$clog2(width+1)`
  - No wrap-around is permitted inside a frame.
- All outputs are registered. There are no combinational paths from inputs to `o_*`. `i_ready` depends on state only, never on `i_valid`.

## Timing
- Let T be the accept cycle (rising edge where `i_valid && i_ready`).
- T+1: state = SHIFT, `i_ready` = 0, `o_sdata` = `i_array[width-1]`, `o_sclk` = 0.
- Bit k (k = 0 … `width-1`):
  - low phase starts at T+1+2k·`clk_div`
  - `o_sclk` rises at T+1+(2k+1)·`clk_div`
  - `o_sclk` falls, and `o_sdata` changes to the next bit, at T+1+(2k+2)·`clk_div`
- `o_latch` rises at T+1+2·`width`·`clk_div`, the same cycle as the final `o_sclk` fall. It is high for `clk_div` cycles.
- `i_ready` returns to 1 at T+1+(2·`width`+1)·`clk_div`.
- Back-to-back frames with `i_valid` held high are accepted every 1+(2·`width`+1)·`clk_div` cycles.
- `o_sdata` never changes while `o_sclk` = 1. The setup and hold margin to the rising `o_sclk` edge is `clk_div` cycles each.
- There are no `o_sclk` edges during LATCH or IDLE.

## Test plan
- **Reset values:** assert `reset` for 3 cycles with `i_valid` = 1. Required response: `o_sclk` = `o_sdata` = `o_latch` = 0 throughout, no accept during reset, and `i_ready` = 1 on the first cycle after release.
- **Single frame:** `width` = 8, `clk_div` = 2, send 8'hA5.
  - Exactly 8 `o_sclk` rising edges.
  - `o_sdata` sampled at those edges = 1,0,1,0,0,1,0,1.
  - `o_latch` high for exactly 2 cycles starting at T+33.
  - `i_ready` = 1 at T+35.
- **Back-to-back:** `width` = 8, `clk_div` = 2, `i_valid` held high with 8'hFF then 8'h00. Required response: accepts spaced exactly 35 cycles apart, the second frame samples eight 0s, and two latch pulses are seen.
- **Input changes while busy:** accept 8'h0F, then drive `i_array` = 8'hF0 with `i_valid` = 1 while busy. Required response: sampled bits are 0,0,0,0,1,1,1,1, and 8'hF0 is accepted only when `i_ready` returns.
- **Reset mid-frame:** assert `reset` after the 3rd rising `o_sclk` edge. Required response: all outputs 0 on the next cycle, no `o_latch` pulse, `i_ready` = 1 after release, and a following 8'h81 frame is sent complete and correct.
- **Minimum parameters:** `width` = 1, `clk_div` = 1, `i_valid` held high with alternating 1/0. Required response:
  - frame period of 4 cycles
  - `o_sclk` pattern 0,1,0,0 per frame
  - `o_latch` on the 3rd cycle of each frame
  - `o_sdata` matches the input at each rising edge

Source files
------------

// File: rtl/indicator_shift_out_if.sv
// indicator_shift_out_if: indicator frame stream in, three-wire LED chain out
interface indicator_shift_out_if #(
    parameter int width = 32
);
    logic             i_valid;
    logic             i_ready;
    logic [width-1:0] i_array;
    logic             o_sclk;
    logic             o_sdata;
    logic             o_latch;
    modport master (output i_valid, i_array, input i_ready, o_sclk, o_sdata, o_latch);
    modport slave  (input i_valid, i_array, output i_ready, o_sclk, o_sdata, o_latch);
endinterface

// File: rtl/indicator_shift_out.sv
// indicator_shift_out: serializes one indicator frame MSB-first onto an sclk/sdata/latch LED chain
module indicator_shift_out #(
    parameter int width   = 32,
    parameter int clk_div = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    indicator_shift_out_if.slave   bus
);
    localparam int PW = $clog2(clk_div + 1);
    localparam int BW = $clog2(width + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(clk_div - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(width - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ph_q, ph_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             hi_q, hi_d;
    logic [width-1:0] sr_q, sr_d;
    logic             sclk_q, sdata_q, latch_q;
    logic             ph_end;

    assign ph_end      = ph_q == PH_LAST;
    assign bus.i_ready = state_q == IDLE;
    assign bus.o_sclk  = sclk_q;
    assign bus.o_sdata = sdata_q;
    assign bus.o_latch = latch_q;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        hi_d    = hi_q;
        sr_d    = sr_q;
        case (state_q)
            IDLE: if (bus.i_valid) begin
                state_d = SHIFT;
                sr_d    = bus.i_array;
                ph_d    = '0;
                bit_d   = '0;
                hi_d    = 1'b0;
            end
            SHIFT: begin
                ph_d = ph_end ? '0 : ph_q + 1'b1;
                if (ph_end) begin
                    hi_d = !hi_q;
                    // a bit completes at the end of its high half-period
                    if (hi_q) begin
                        sr_d    = sr_q << 1;
                        bit_d   = bit_q + 1'b1;
                        state_d = (bit_q == BIT_LAST) ? LATCH : SHIFT;
                    end
                end
            end
            LATCH: begin
                ph_d    = ph_end ? '0 : ph_q + 1'b1;
                state_d = ph_end ? IDLE : LATCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered from next-state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            hi_q    <= 1'b0;
            sr_q    <= '0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            hi_q    <= hi_d;
            sr_q    <= sr_d;
            sclk_q  <= (state_d == SHIFT) && hi_d;
            sdata_q <= (state_d == SHIFT) && sr_d[width-1];
            latch_q <= state_d == LATCH;
        end
    end
endmodule

// File: tb/tb_indicator_shift_out.sv
// tb_indicator_shift_out: directed checks of framing, timing, back-pressure and reset abort
module tb_indicator_shift_out;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    indicator_shift_out_if #(.width(8)) b8();
    indicator_shift_out_if #(.width(1)) b1();

    indicator_shift_out #(.width(8), .clk_div(2)) u8 (.clk(clk), .reset(reset), .bus(b8.slave));
    indicator_shift_out #(.width(1), .clk_div(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] d, input logic hold, input logic [7:0] nxt);
        b8.i_valid = 1'b1;
        b8.i_array = d;
        step;
        b8.i_valid = hold;
        b8.i_array = nxt;
    endtask

    // n counts cycles after the accept edge: n=1 is the cycle labelled T+1
    task automatic watch(output logic [7:0] bits, output int rises, output int lstart,
                         output int llen, output int rdy, output int viol);
        logic ps = 1'b0;
        logic pd = 1'b0;
        bits = '0; rises = 0; lstart = 0; llen = 0; rdy = 0; viol = 0;
        for (int n = 1; n <= 100; n++) begin
            if (b8.o_sclk && !ps) begin
                rises++;
                bits = {bits[6:0], b8.o_sdata};
            end
            if (b8.o_sclk && ps && b8.o_sdata !== pd) viol++;
            if (b8.o_latch) begin
                if (llen == 0) lstart = n;
                llen++;
            end
            if (b8.i_ready) begin
                rdy = n;
                break;
            end
            ps = b8.o_sclk;
            pd = b8.o_sdata;
            step;
        end
    endtask

    task automatic frame_chk(input string tag, input logic [7:0] exp);
        logic [7:0] bits;
        int rises, lstart, llen, rdy, viol;
        watch(bits, rises, lstart, llen, rdy, viol);
        chk({tag, "_bits"}, bits, exp);
        chk({tag, "_rises"}, rises, 8);
        chk({tag, "_latch_start"}, lstart, 33);
        chk({tag, "_latch_len"}, llen, 2);
        chk({tag, "_ready_at"}, rdy, 35);
        chk({tag, "_sdata_moved_high"}, viol, 0);
    endtask

    initial begin
        int r, lat, sc;
        logic ps, d;
        b8.i_valid = 1'b1;
        b8.i_array = 8'h3C;
        b1.i_valid = 1'b0;
        b1.i_array = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            step;
            chk("rst_sclk", b8.o_sclk, 0);
            chk("rst_sdata", b8.o_sdata, 0);
            chk("rst_latch", b8.o_latch, 0);
            chk("rst_no_accept", b8.i_ready, 1);
        end
        reset = 1'b0;
        b8.i_valid = 1'b0;
        chk("rel_ready", b8.i_ready, 1);
        chk("rel_ready_w1", b1.i_ready, 1);
        step;
        chk("idle_ready", b8.i_ready, 1);
        chk("idle_sclk", b8.o_sclk, 0);

        accept(8'hA5, 1'b0, 8'h00);
        chk("t1_ready", b8.i_ready, 0);
        chk("t1_sdata", b8.o_sdata, 1);
        chk("t1_sclk", b8.o_sclk, 0);
        frame_chk("a5", 8'hA5);

        accept(8'hFF, 1'b1, 8'h00);
        frame_chk("ff", 8'hFF);
        step;
        b8.i_valid = 1'b0;
        chk("b2b_accept", b8.i_ready, 0);
        frame_chk("00", 8'h00);

        accept(8'h0F, 1'b1, 8'hF0);
        frame_chk("0f", 8'h0F);
        step;
        b8.i_valid = 1'b0;
        chk("busy_accept", b8.i_ready, 0);
        chk("busy_first_bit", b8.o_sdata, 1);
        frame_chk("f0", 8'hF0);

        accept(8'hC3, 1'b0, 8'h00);
        r = 0;
        ps = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (b8.o_sclk && !ps) r++;
            if (r == 3) break;
            ps = b8.o_sclk;
            step;
        end
        chk("mid_rises", r, 3);
        reset = 1'b1;
        step;
        chk("mid_sclk", b8.o_sclk, 0);
        chk("mid_sdata", b8.o_sdata, 0);
        chk("mid_latch", b8.o_latch, 0);
        chk("mid_ready", b8.i_ready, 1);
        reset = 1'b0;
        lat = 0;
        sc = 0;
        repeat (20) begin
            step;
            lat += int'(b8.o_latch);
            sc += int'(b8.o_sclk);
        end
        chk("mid_no_latch", lat, 0);
        chk("mid_no_sclk", sc, 0);
        chk("mid_ready_after", b8.i_ready, 1);
        accept(8'h81, 1'b0, 8'h00);
        frame_chk("81", 8'h81);

        b1.i_valid = 1'b1;
        b1.i_array = 1'b1;
        step;
        for (int f = 0; f < 4; f++) begin
            d = (f % 2 == 0);
            b1.i_array = !d;
            for (int k = 1; k <= 4; k++) begin
                chk("min_sclk", b1.o_sclk, k == 2);
                chk("min_latch", b1.o_latch, k == 3);
                chk("min_ready", b1.i_ready, k == 4);
                if (k == 2) chk("min_sdata", b1.o_sdata, d);
                step;
            end
        end
        b1.i_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
